// File: rtl/alu_pkg.sv
// Shared execute-stage definitions: divider op encodings, iteration count and FSM states.
package alu_pkg;

    localparam int DIV_ITER = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Divider request/response bundle: start/ctrl/operands in, busy/valid/result out.
interface div_unit_if #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int CTRL_WIDTH     = 2
);
    logic                      start;
    logic [CTRL_WIDTH-1:0]     ctrl;
    logic [REG_DATA_WIDTH-1:0] din_0;
    logic [REG_DATA_WIDTH-1:0] din_1;
    logic                      busy;
    logic                      valid;
    logic [REG_DATA_WIDTH-1:0] result;

    modport master (
        output start, ctrl, din_0, din_1,
        input  busy, valid, result
    );

    modport slave (
        input  start, ctrl, din_0, din_1,
        output busy, valid, result
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract, keep or restore.
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] dvs,
    output logic [W-1:0] rem_nxt,
    output logic [W-1:0] quo_nxt
);
    logic [W:0] shifted;
    logic [W:0] diff;

    assign shifted = {rem, quo[W-1]};
    assign diff    = shifted - {1'b0, dvs};

    // rem < dvs always holds, so a non-negative difference fits back into W bits
    always_comb begin
        rem_nxt = shifted[W-1:0];
        quo_nxt = {quo[W-2:0], 1'b0};
        if (!diff[W]) begin
            rem_nxt = diff[W-1:0];
            quo_nxt = {quo[W-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per clock.
// DIV_EARLY_OUT_EN: resolve divide-by-zero and signed overflow in IDLE and skip the iterations.
module div_unit
    import alu_pkg::*;
#(
    parameter int REG_DATA_WIDTH = DIV_ITER,
    parameter int CTRL_WIDTH     = 2
) (
    input  logic       clk,
    input  logic       reset,
    div_unit_if.slave  bus
);
    localparam int W  = REG_DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    div_state_t    state_q, state_nxt;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  rem_q, quo_q, dvs_q;
    div_op_t       op_q;
    logic          neg_quo_q, neg_rem_q, dz_q;
    logic [W-1:0]  result_q;
    logic          busy_q, valid_q;

    logic          load, iter, write;
    logic [W-1:0]  wr_val;

    logic          is_signed, sign0, sign1, dz_in;
    logic [W-1:0]  abs0, abs1;
    logic [W-1:0]  step_rem, step_quo;
    logic [W-1:0]  quo_fix, rem_fix, final_res;

    assign is_signed = ~bus.ctrl[0];
    assign sign0     = is_signed & bus.din_0[W-1];
    assign sign1     = is_signed & bus.din_1[W-1];
    assign abs0      = sign0 ? -bus.din_0 : bus.din_0;
    assign abs1      = sign1 ? -bus.din_1 : bus.din_1;
    assign dz_in     = (bus.din_1 == '0);

    div_step #(.W(W)) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .dvs     (dvs_q),
        .rem_nxt (step_rem),
        .quo_nxt (step_quo)
    );

    // Negation wraps at W bits, which gives the overflow case 0x8000_0000 / -1 for free
    assign quo_fix   = neg_quo_q ? -step_quo : step_quo;
    assign rem_fix   = neg_rem_q ? -step_rem : step_rem;
    assign final_res = op_q[1] ? rem_fix : (dz_q ? '1 : quo_fix);

`ifdef DIV_EARLY_OUT_EN
    logic         ovf_in, early_hit;
    logic [W-1:0] early_res;

    assign ovf_in    = is_signed && (bus.din_0 == {1'b1, {(W-1){1'b0}}}) && (bus.din_1 == '1);
    assign early_hit = dz_in | ovf_in;
    // Overflow quotient equals the dividend itself; its remainder is zero
    assign early_res = dz_in ? (bus.ctrl[1] ? bus.din_0 : '1)
                             : (bus.ctrl[1] ? '0 : bus.din_0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        load      = 1'b0;
        iter      = 1'b0;
        write     = 1'b0;
        wr_val    = final_res;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = CALC;
`ifdef DIV_EARLY_OUT_EN
                    if (early_hit) begin
                        load      = 1'b0;
                        write     = 1'b1;
                        wr_val    = early_res;
                        state_nxt = DONE;
                    end
`endif
                end
            end
            CALC: begin
                iter = 1'b1;
                if (cnt_q == LAST) begin
                    write     = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            op_q      <= OP_DIV;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            if (load) begin
                cnt_q     <= '0;
                rem_q     <= '0;
                quo_q     <= abs0;
                dvs_q     <= abs1;
                op_q      <= div_op_t'(bus.ctrl[1:0]);
                neg_quo_q <= sign0 ^ sign1;
                neg_rem_q <= sign0;
                dz_q      <= is_signed & dz_in;
            end
            if (iter) begin
                cnt_q <= cnt_q + 1'b1;
                rem_q <= step_rem;
                quo_q <= step_quo;
            end
            if (write) result_q <= wr_val;
            busy_q  <= (state_nxt != IDLE);
            valid_q <= (state_nxt == DONE);
        end
    end

    assign bus.busy   = busy_q;
    assign bus.valid  = valid_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed-vector and random-reference bench for div_unit, including abort and busy-ignore sequences.
module tb_div_unit;
    import alu_pkg::*;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 0;
`else
    localparam int SPECIAL_LAT = 32;
`endif
    localparam int NORMAL_LAT = 32;

    div_unit_if #(.REG_DATA_WIDTH(32), .CTRL_WIDTH(2)) bus ();

    div_unit #(.REG_DATA_WIDTH(32), .CTRL_WIDTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        if (b == 32'd0) return c[1] ? a : 32'hFFFF_FFFF;
        if (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return c[1] ? 32'd0 : 32'h8000_0000;
        sa = a;
        sb = b;
        case (c)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    // Returns the index k of the edge E_k after which valid was first seen (E0 = accepting edge)
    task automatic do_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.ctrl  = c;
        bus.din_0 = a;
        bus.din_1 = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.din_0 = $urandom;
        bus.din_1 = $urandom;
        bus.ctrl  = 2'($urandom);
        lat = 0;
        while (!bus.valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res = bus.result;
    endtask

    vec_t        vecs[18];
    logic [31:0] res, a, b, first_res;
    int          lat, vcount;
    bit          busy_drop, busy_stuck;

    initial begin
        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         1'b0};
        vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          1'b0};
        vecs[2]  = '{OP_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  1'b0};
        vecs[3]  = '{OP_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  1'b0};
        vecs[4]  = '{OP_REM,  32'd100,        32'hFFFF_FFF9,  32'd2,          1'b0};
        vecs[5]  = '{OP_DIV,  32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  1'b1};
        vecs[6]  = '{OP_DIVU, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  1'b1};
        vecs[7]  = '{OP_REM,  32'h1234_5678,  32'd0,          32'h1234_5678,  1'b1};
        vecs[8]  = '{OP_REMU, 32'h1234_5678,  32'd0,          32'h1234_5678,  1'b1};
        vecs[9]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
        vecs[10] = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1};
        vecs[11] = '{OP_DIV,  32'hFFFF_FF9C,  32'd0,          32'hFFFF_FFFF,  1'b1};
        vecs[12] = '{OP_REM,  32'hFFFF_FF9C,  32'd0,          32'hFFFF_FF9C,  1'b1};
        vecs[13] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0};
        vecs[14] = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
        vecs[15] = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0};
        vecs[16] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[17] = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.ctrl  = 2'b00;
        bus.din_0 = '0;
        bus.din_1 = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",   {31'd0, bus.busy},  32'd0);
        check("reset_valid",  {31'd0, bus.valid}, 32'd0);
        check("reset_result", bus.result,         32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'd0, bus.busy}, 32'd0);

        // Directed table
        for (int i = 0; i < 18; i++) begin
            do_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat),
                  32'(vecs[i].special ? SPECIAL_LAT : NORMAL_LAT));
            check($sformatf("vec%0d_busy_in_done", i), {31'd0, bus.busy}, 32'd1);
            @(negedge clk);
            check($sformatf("vec%0d_valid_pulse", i), {31'd0, bus.valid}, 32'd0);
            check($sformatf("vec%0d_busy_idle", i), {31'd0, bus.busy}, 32'd0);
        end

        // Start pulses while busy (mid-CALC and during DONE) must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.ctrl = OP_DIVU; bus.din_0 = 32'd1000; bus.din_1 = 32'd10;
        @(posedge clk);
        vcount = 0; busy_drop = 0; busy_stuck = 0; first_res = '0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            bus.start = (k == 5 || k == 32);
            bus.ctrl  = OP_REM;
            bus.din_0 = 32'd77 + 32'(k);
            bus.din_1 = 32'd3;
            if (bus.valid) begin
                vcount++;
                first_res = bus.result;
            end
            if (k <= 32 && !bus.busy) busy_drop = 1;
            if (k >= 34 && bus.busy) busy_stuck = 1;
        end
        bus.start = 1'b0;
        check("ignore_valid_count", 32'(vcount),        32'd1);
        check("ignore_result",      first_res,          32'd100);
        check("ignore_busy_held",   {31'd0, busy_drop}, 32'd0);
        check("ignore_no_restart",  {31'd0, busy_stuck}, 32'd0);
        check("ignore_result_hold", bus.result,         32'd100);

        // Asynchronous reset with the counter at 10 discards the operation
        @(negedge clk);
        bus.start = 1'b1; bus.ctrl = OP_DIVU; bus.din_0 = 32'd1000; bus.din_1 = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy",   {31'd0, bus.busy},  32'd0);
        check("abort_valid",  {31'd0, bus.valid}, 32'd0);
        check("abort_result", bus.result,         32'd0);
        @(negedge clk);
        reset  = 1'b0;
        vcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.valid || bus.busy) vcount++;
        end
        check("abort_no_completion", 32'(vcount), 32'd0);
        do_op(OP_DIVU, 32'd50, 32'd5, res, lat);
        check("post_abort_result",  res,      32'd10);
        check("post_abort_latency", 32'(lat), 32'(NORMAL_LAT));

        // Random operands against the reference model
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 100; i++) begin
                a = $urandom;
                b = $urandom >> $urandom_range(0, 31);
                if ($urandom_range(0, 1) == 1) b = -b;
                if (b == 32'd0) b = 32'd1;
                do_op(2'(c), a, b, res, lat);
                check($sformatf("rand_c%0d_%0d a=%08h b=%08h", c, i, a, b), res, ref_div(2'(c), a, b));
                if (lat != NORMAL_LAT)
                    check($sformatf("rand_c%0d_%0d_latency", c, i), 32'(lat), 32'(NORMAL_LAT));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative multi-cycle integer divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Performs the inverse operation of the multiplier path and sits beside the single-cycle ALU in the execute stage.
- Presents the same operand/ctrl/result naming as the ALU, plus a start/busy/valid handshake.
- Uses restoring division, one quotient bit per clock.

Parameters:
- REG_DATA_WIDTH, 32, operand and result width.
- CTRL_WIDTH, 2, op select width; equals funct3[1:0] of the M-extension divide ops.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  reset; one clock; reset is asynchronous and active-high.
- start  in  1  request; sampled only when busy=0.
- ctrl  in  CTRL_WIDTH  00 DIV, 01 DIVU, 10 REM, 11 REMU; latched with start.
- din_0  in  REG_DATA_WIDTH  dividend; latched with start.
- din_1  in  REG_DATA_WIDTH  divisor; latched with start.
- busy  out  1  high from the accepting edge until return to IDLE.
- valid  out  1  one-cycle pulse; result is valid in that cycle.
- result  out  REG_DATA_WIDTH  registered quotient or remainder; holds until the next completion.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, valid=0, result=0, counter=0, internal regs=0. An in-flight operation is discarded, not completed.
- States:
  - IDLE: start=1 at an edge latches ctrl and operands and goes to CALC. Signed ops (ctrl[0]=0) latch |din_0|, |din_1| and record sign_q = sign0 XOR sign1 (quotient sign) and sign_r = sign0 (remainder sign).
  - CALC: 5-bit counter 0..31. Each edge shifts {rem, quo} left 1 and trial-subtracts the divisor from the 33-bit partial remainder. If non-negative, keep the difference and set quo[0]=1; else restore. Edge at counter=31 writes result and goes to DONE.
  - DONE: valid=1 for exactly one cycle, then IDLE.
- Result write: quotient or remainder selected by ctrl[1]; two's-complement negation applied per sign_q / sign_r for signed ops.
- Latency: start accepted at edge E0; valid high in the cycle after edge E32; busy falls at E33. Throughput is one op per 34 cycles.
- start while busy=1 (including the DONE cycle) is ignored, with no queuing. Operand changes during busy are ignored.
- Divide by zero (RISC-V defined, no trap):
  - DIV/DIVU result = 0xFFFFFFFF.
  - REM/REMU result = dividend (original signed value).
  - The iteration naturally yields these values; the unsigned path needs no special case.
  - Signed DIV by 0 must force all-ones regardless of dividend sign.
- Signed overflow (din_0=0x80000000, din_1=0xFFFFFFFF): DIV result = 0x80000000, REM result = 0. Achieved by 32-bit wrap of the negation.
- result changes only on the write edge; valid and busy are registered, not combinational.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, divide-by-zero and signed overflow are detected from din_0/din_1/ctrl. The unit writes the special-case result at E0 and goes directly to DONE. valid is high in the cycle after E0, and busy falls at E1.
- Undefined: all operations take the full 32-iteration path with identical result values. No detection logic is synthesised.

Decomposition:
- Shared package alu_pkg holds:
  - The div_op_t enum (DIV/DIVU/REM/REMU encodings).
  - DIV_ITER = REG_DATA_WIDTH.
  - The div_state_t enum (IDLE, CALC, DONE).
- Sub-module div_step: purely combinational single restoring iteration. Inputs partial remainder, quotient, divisor; outputs next remainder and quotient. Instantiated once inside div_unit.

Test Plan:
1. DIVU 100 / 7, then REMU 100 / 7 -> 14 and 2; valid exactly 33 cycles after the start edge; busy low in IDLE.
2. DIV -100 / 7 -> 0xFFFFFFF2 (-14). REM -100 / 7 -> 0xFFFFFFFE (-2). REM 100 / -7 -> 2.
3. DIV and DIVU 0x12345678 / 0 -> 0xFFFFFFFF; REM and REMU -> 0x12345678. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0. With DIV_EARLY_OUT_EN, each special case has valid 1 cycle after start.
4. Second start pulsed at cycles 5 and 33 of a running op, with different operands -> ignored. Result equals the first op; busy stays high; no extra valid.
5. reset asserted asynchronously mid-CALC (counter=10) -> busy=0, valid=0, result=0 immediately, with no valid pulse. Next start 50 / 5 DIVU -> 10.
6. 100 random signed/unsigned operand pairs per ctrl (nonzero divisor) -> result matches the reference model (quotient truncated toward zero; remainder sign follows dividend).
